seg7_reg_monitor: RTL and testbench

SEG7_REG_MONITOR -- requirements
Module: seg7_reg_monitor

---
 rtl/seg7_reg_monitor.sv | 61 ++++++
 tb/tb_seg7_reg_monitor.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/seg7_reg_monitor.sv
// seg7_reg_monitor: debounced button steps reg_sel; 8-digit hex display of the selected register.
module seg7_reg_monitor #(
  parameter int SCAN_DIV = 100000,
  parameter int DB_CNT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_next,
  input  logic [31:0] reg_data,
  output logic [4:0]  reg_sel,
  output logic [7:0]  an,
  output logic [7:0]  seg
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DB_CNT + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CNT - 1);
  localparam logic [127:0] GLYPHS = 128'h8E86A1C6_83889080_F8829299_B0A4F9C0;
  logic s1, s2, db_lvl;
  logic [CW-1:0] db_cnt;
  logic [DW-1:0] div;
  logic [2:0] idx, idx_nxt;
  logic [31:0] snap, snap_nxt;
  logic [3:0] nib;
  logic flip, step, tick, load;
  // an/seg are computed from next-state index and snapshot so they switch with idx
  always_comb begin
    flip = (s2 != db_lvl) && (db_cnt == DB_MAX);
    step = flip && !db_lvl;
    tick = div == DIV_MAX;
    load = tick && idx == 3'd7;
    idx_nxt = tick ? idx + 3'd1 : idx;
    snap_nxt = load ? reg_data : snap;
    nib = snap_nxt[4*idx_nxt +: 4];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      db_lvl <= 1'b0;
      db_cnt <= '0;
      reg_sel <= '0;
      div <= '0;
      idx <= '0;
      snap <= '0;
      an <= 8'hFE;
      seg <= 8'hC0;
    end else begin
      s1 <= btn_next;
      s2 <= s1;
      db_lvl <= db_lvl ^ flip;
      db_cnt <= (s2 == db_lvl || flip) ? '0 : db_cnt + CW'(1);
      reg_sel <= reg_sel + 5'(step);
      div <= tick ? '0 : div + DW'(1);
      idx <= idx_nxt;
      snap <= snap_nxt;
      an <= ~(8'b1 << idx_nxt);
      seg <= {1'b1, GLYPHS[8*nib +: 7]};
    end
  end
endmodule

// File: tb/tb_seg7_reg_monitor.sv
// tb_seg7_reg_monitor: directed checks of scan, display, debounce, wrap and reset behaviour.
module tb_seg7_reg_monitor;
  logic clk = 1'b0, rst = 1'b1, btn_next = 1'b0;
  logic [31:0] reg_data = '0;
  logic [4:0] reg_sel;
  logic [7:0] an, seg;
  int checks = 0, fails = 0;
  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg7_reg_monitor #(.SCAN_DIV(4), .DB_CNT(3)) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .reg_data(reg_data),
    .reg_sel(reg_sel), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_next = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic press();
    btn_next = 1'b1;
    cyc(8);
    btn_next = 1'b0;
    cyc(8);
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst = 1'b1;
    reg_data = '0;
    cyc(2);
    checks += 3;
    if (an !== 8'hFE) begin fails++; $display("FAIL reset_an got %h want fe", an); end
    if (seg !== 8'hC0) begin fails++; $display("FAIL reset_seg got %h want c0", seg); end
    if (reg_sel !== 5'd0) begin fails++; $display("FAIL reset_sel got %0d want 0", reg_sel); end
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      e = ~(8'b1 << ((k / 4) % 8));
      checks += 2;
      if (an !== e) begin fails++; $display("FAIL scan_an k=%0d got %h want %h", k, an, e); end
      if (seg !== 8'hC0) begin fails++; $display("FAIL scan_seg k=%0d got %h want c0", k, seg); end
    end
  endtask

  task automatic test_display();
    logic [31:0] v;
    logic [7:0] e, ea;
    int d;
    rst = 1'b1;
    reg_data = 32'h89ABCDEF;
    cyc(1);
    rst = 1'b0;
    for (int k = 1; k <= 71; k++) begin
      cyc(1);
      d = (k / 4) % 8;
      v = (k < 64) ? 32'h89ABCDEF : 32'h12345670;
      e = (k < 32) ? 8'hC0 : glyph[(v >> (4 * d)) & 32'hF];
      ea = ~(8'b1 << d);
      checks += 2;
      if (seg !== e) begin fails++; $display("FAIL disp_seg k=%0d got %h want %h", k, seg, e); end
      if (an !== ea) begin fails++; $display("FAIL disp_an k=%0d got %h want %h", k, an, ea); end
      if (k == 40) reg_data = 32'h12345670;
    end
  endtask

  task automatic test_press();
    logic [4:0] e;
    do_reset();
    btn_next = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      e = (k >= 5) ? 5'd1 : 5'd0;
      checks++;
      if (reg_sel !== e) begin fails++; $display("FAIL press k=%0d got %0d want %0d", k, reg_sel, e); end
    end
    btn_next = 1'b0;
    cyc(10);
    checks++;
    if (reg_sel !== 5'd1) begin fails++; $display("FAIL press_release got %0d want 1", reg_sel); end
  endtask

  task automatic test_glitch();
    do_reset();
    btn_next = 1'b1;
    cyc(2);
    btn_next = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      cyc(1);
      checks++;
      if (reg_sel !== 5'd0) begin fails++; $display("FAIL glitch k=%0d got %0d want 0", k, reg_sel); end
    end
  endtask

  task automatic test_wrap();
    logic [4:0] e;
    do_reset();
    for (int i = 1; i <= 32; i++) begin
      press();
      e = 5'(i);
      checks++;
      if (reg_sel !== e) begin fails++; $display("FAIL wrap press=%0d got %0d want %0d", i, reg_sel, e); end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    press();
    btn_next = 1'b1;
    cyc(3);
    checks += 2;
    if (reg_sel !== 5'd1) begin fails++; $display("FAIL pre_rst_sel got %0d want 1", reg_sel); end
    if (an === 8'hFE) begin fails++; $display("FAIL pre_rst_an got %h want not fe", an); end
    rst = 1'b1;
    #1;
    checks += 3;
    if (reg_sel !== 5'd0) begin fails++; $display("FAIL mid_rst_sel got %0d want 0", reg_sel); end
    if (an !== 8'hFE) begin fails++; $display("FAIL mid_rst_an got %h want fe", an); end
    if (seg !== 8'hC0) begin fails++; $display("FAIL mid_rst_seg got %h want c0", seg); end
    cyc(2);
    btn_next = 1'b0;
    rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      cyc(1);
      checks++;
      if (reg_sel !== 5'd0) begin fails++; $display("FAIL post_rst k=%0d got %0d want 0", k, reg_sel); end
    end
  endtask

  initial begin
    test_reset();
    test_display();
    test_press();
    test_glitch();
    test_wrap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
